linebuf_read_ctrl: RTL and testbench

Read-side controller for the ping/pong line-buffer pair. It drains each buffer bank once the write-side controller marks it full. It issues read enables and addresses to the selected bank and streams returned pixels, with column and row tags, to the convolution datapath under a valid/ready handshake. It sits between the ping/pong buffer RAMs and the kernel window/MAC array, and returns each bank to the writer with a release pulse.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/linebuf_read_ctrl_rd_addr_gen.sv | 31 +++
 rtl/linebuf_read_ctrl.sv | 113 +++++++++++
 tb/tb_linebuf_read_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and derived geometry for the line-buffer / convolution front end.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        DRAIN   = 2'd2,
        RELEASE = 2'd3
    } rd_state_t;

    localparam logic PING = 1'b0;
    localparam logic PONG = 1'b1;

    localparam int DEF_IMAGE_SIZE  = 16;
    localparam int DEF_KERNEL_SIZE = 3;

    // Valid (unpadded) convolution output extent along one axis.
    function automatic int out_dim(input int image_size, input int kernel_size);
        return image_size - kernel_size + 1;
    endfunction

    localparam int OUT_COLS = out_dim(DEF_IMAGE_SIZE, DEF_KERNEL_SIZE);
    localparam int OUT_ROWS = out_dim(DEF_IMAGE_SIZE, DEF_KERNEL_SIZE);

endpackage

// File: rtl/linebuf_read_ctrl_rd_addr_gen.sv
// Enable-driven buffer read address counter with synchronous clear and last-address flag.
module rd_addr_gen #(
    parameter int ADDR_SIZE = 4,
    parameter int LAST_ADDR = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    output logic [ADDR_SIZE-1:0] addr,
    output logic                 last
);

    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(LAST_ADDR);

    logic [ADDR_SIZE-1:0] addr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg <= '0;
        end else if (clr) begin
            addr_reg <= '0;
        end else if (en) begin
            addr_reg <= addr_reg + 1'b1;
        end
    end

    assign addr = addr_reg;
    assign last = (addr_reg == LAST);

endmodule

// File: rtl/linebuf_read_ctrl.sv
// Drains the ping/pong line buffers in alternation and streams column/row tagged
// pixels to the window datapath, handing each bank back to the writer when done.
module linebuf_read_ctrl
    import conv_pkg::*;
#(
    parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int ADDR_SIZE   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           bank_full,
    output logic [1:0]           bank_release,
    output logic                 rd_en,
    output logic                 rd_bank,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic                 pix_valid,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [ADDR_SIZE-1:0] col,
    output logic [ADDR_SIZE-1:0] row_cnt,
    output logic                 frame_done,
    output logic                 busy
);

    localparam logic [ADDR_SIZE-1:0] LAST_ROW  = ADDR_SIZE'(out_dim(IMAGE_SIZE, KERNEL_SIZE) - 1);
    localparam logic [ADDR_SIZE-1:0] WIN_START = ADDR_SIZE'(KERNEL_SIZE - 1);

    rd_state_t            state_reg;
    logic                 exp_bank_reg;
    logic                 pix_valid_reg;
    logic [ADDR_SIZE-1:0] col_reg;
    logic [ADDR_SIZE-1:0] row_cnt_reg;
    logic [1:0]           bank_release_reg;
    logic                 frame_done_reg;
    logic                 addr_last;
    logic                 accept;

    // The RAM holds its output while rd_en is low, so a stalled pixel simply stays put.
    assign rd_en  = (state_reg == READ) && (!pix_valid_reg || win_ready);
    assign accept = pix_valid_reg && win_ready;

    rd_addr_gen #(
        .ADDR_SIZE (ADDR_SIZE),
        .LAST_ADDR (IMAGE_SIZE - 1)
    ) u_addr (
        .clk  (clk),
        .rst  (rst),
        .en   (rd_en),
        .clr  (state_reg == RELEASE),
        .addr (rd_addr),
        .last (addr_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            exp_bank_reg     <= PING;
            pix_valid_reg    <= 1'b0;
            col_reg          <= '0;
            row_cnt_reg      <= '0;
            bank_release_reg <= 2'b00;
            frame_done_reg   <= 1'b0;
        end else begin
            bank_release_reg <= 2'b00;
            frame_done_reg   <= 1'b0;

            if (rd_en) begin
                pix_valid_reg <= 1'b1;
                col_reg       <= rd_addr;
            end else if (win_ready) begin
                pix_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (bank_full[exp_bank_reg]) begin
                        state_reg <= READ;
                    end
                end
                READ: begin
                    if (rd_en && addr_last) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Release is registered so it lands in RELEASE, one cycle after the last accept.
                    if (accept) begin
                        state_reg                      <= RELEASE;
                        bank_release_reg[exp_bank_reg] <= 1'b1;
                        frame_done_reg                 <= (row_cnt_reg == LAST_ROW);
                    end
                end
                RELEASE: begin
                    exp_bank_reg <= ~exp_bank_reg;
                    row_cnt_reg  <= (row_cnt_reg == LAST_ROW) ? '0 : row_cnt_reg + 1'b1;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bank_release = bank_release_reg;
    assign frame_done   = frame_done_reg;
    assign rd_bank      = exp_bank_reg;
    assign pix_valid    = pix_valid_reg;
    assign col          = col_reg;
    assign row_cnt      = row_cnt_reg;
    assign win_valid    = pix_valid_reg && (col_reg >= WIN_START);
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_linebuf_read_ctrl.sv
// Scoreboard bench: stimulus queues the expected pixel stream and bank releases,
// an independent monitor pops and compares whatever the controller presents.
module tb_linebuf_read_ctrl;
    import conv_pkg::*;

    localparam int IMG = 16;
    localparam int K   = 3;

    typedef struct {
        logic bank;
        int   row;
        int   col;
    } pix_t;

    typedef struct {
        logic bank;
        logic fd;
    } rel_t;

    logic       clk;
    logic       rst;
    logic [1:0] bank_full;
    logic [1:0] bank_release;
    logic       rd_en;
    logic       rd_bank;
    logic [3:0] rd_addr;
    logic       pix_valid;
    logic       win_valid;
    logic       win_ready;
    logic [3:0] col;
    logic [3:0] row_cnt;
    logic       frame_done;
    logic       busy;

    int   tests;
    int   fails;
    int   cyc;
    pix_t pix_q[$];
    rel_t rel_q[$];
    int   rows_issued;

    // Writer model controls
    int         fills_req;
    logic       fast_fill;
    logic       ovr_en;
    logic [1:0] ovr_val;
    int         ready_mode;

    linebuf_read_ctrl #(
        .IMAGE_SIZE  (IMG),
        .KERNEL_SIZE (K),
        .ADDR_SIZE   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .rd_en        (rd_en),
        .rd_bank      (rd_bank),
        .rd_addr      (rd_addr),
        .pix_valid    (pix_valid),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .col          (col),
        .row_cnt      (row_cnt),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected stream: the n-th row served since reset comes from bank n%2, is output row n%OUT_ROWS.
    task automatic push_rows(input int n);
        for (int k = 0; k < n; k++) begin
            pix_t p;
            rel_t r;
            p.bank = (rows_issued % 2 == 1) ? PONG : PING;
            p.row  = rows_issued % OUT_ROWS;
            for (int c = 0; c < IMG; c++) begin
                p.col = c;
                pix_q.push_back(p);
            end
            r.bank = p.bank;
            r.fd   = (p.row == OUT_ROWS - 1);
            rel_q.push_back(r);
            rows_issued++;
        end
        fills_req += n;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (rel_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("rows_done_in_time", rel_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bank_release"}, int'(bank_release), 0);
        check({tag, "_rd_en"},        int'(rd_en), 0);
        check({tag, "_rd_bank"},      int'(rd_bank), 0);
        check({tag, "_rd_addr"},      int'(rd_addr), 0);
        check({tag, "_pix_valid"},    int'(pix_valid), 0);
        check({tag, "_win_valid"},    int'(win_valid), 0);
        check({tag, "_col"},          int'(col), 0);
        check({tag, "_row_cnt"},      int'(row_cnt), 0);
        check({tag, "_frame_done"},   int'(frame_done), 0);
        check({tag, "_busy"},         int'(busy), 0);
    endtask

    // Writer model: fills banks in ping/pong order, refills after release, forgets all on reset.
    initial begin
        logic [1:0] w_full;
        logic       nfb;
        int         fills_done;
        w_full     = 2'b00;
        nfb        = 1'b0;
        fills_done = 0;
        bank_full  = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                w_full     = 2'b00;
                nfb        = 1'b0;
                fills_done = fills_req;
            end else begin
                for (int b = 0; b < 2; b++) begin
                    if (w_full[b] && bank_release[b]) w_full[b] = 1'b0;
                end
                if (fills_done < fills_req && !w_full[nfb] &&
                    (fast_fill || $urandom_range(0, 3) == 0)) begin
                    w_full[nfb] = 1'b1;
                    nfb         = ~nfb;
                    fills_done++;
                end
            end
            bank_full = ovr_en ? ovr_val : w_full;
        end
    end

    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1:       win_ready = 1'($urandom_range(0, 1));
                2:       win_ready = 1'b0;
                default: win_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        int   rden_cnt;
        int   wv_cnt;
        int   seen_cyc;
        int   first_rden;
        int   last_acc;
        logic pv_seen;
        pix_t p;
        rel_t r;
        rden_cnt = 0; wv_cnt = 0; seen_cyc = -1; first_rden = -1; last_acc = -1; pv_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rden_cnt = 0; wv_cnt = 0; seen_cyc = -1; first_rden = -1; last_acc = -1; pv_seen = 1'b0;
            end else begin
                if (!busy && seen_cyc < 0 && pix_q.size() > 0 && bank_full[pix_q[0].bank])
                    seen_cyc = cyc;
                if (rd_en) begin
                    if (pix_q.size() == 0) begin
                        check("read_expected", 0, 1);
                    end else begin
                        if (rden_cnt == 0) begin
                            check("start_latency", cyc, seen_cyc + 1);
                            first_rden = cyc;
                        end
                        check("rd_addr", int'(rd_addr), rden_cnt);
                        check("rd_bank_read", int'(rd_bank), int'(pix_q[0].bank));
                    end
                    rden_cnt++;
                end
                if (pix_valid && !pv_seen) begin
                    pv_seen = 1'b1;
                    check("pix_latency", cyc, first_rden + 1);
                end
                if (pix_valid && win_ready) begin
                    if (pix_q.size() == 0) begin
                        check("pixel_expected", 0, 1);
                    end else begin
                        p = pix_q.pop_front();
                        check("col", int'(col), p.col);
                        check("rd_bank_pix", int'(rd_bank), int'(p.bank));
                        check("row_cnt", int'(row_cnt), p.row);
                        check("win_valid", int'(win_valid), (p.col >= K - 1) ? 1 : 0);
                    end
                    if (win_valid) wv_cnt++;
                    last_acc = cyc;
                end
                if (bank_release != 2'b00 || frame_done) begin
                    if (rel_q.size() == 0) begin
                        check("release_expected", 0, 1);
                    end else begin
                        r = rel_q.pop_front();
                        check("bank_release", int'(bank_release), r.bank ? 2 : 1);
                        check("frame_done", int'(frame_done), int'(r.fd));
                        check("reads_per_row", rden_cnt, IMG);
                        check("windows_per_row", wv_cnt, OUT_COLS);
                        check("release_timing", cyc, last_acc + 1);
                        $display("[TB] row released: bank %0d frame_done %0d reads %0d windows %0d",
                                 bank_release[1], frame_done, rden_cnt, wv_cnt);
                    end
                    rden_cnt = 0; wv_cnt = 0; seen_cyc = -1; first_rden = -1; last_acc = -1; pv_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        tests = 0; fails = 0; rows_issued = 0;
        fills_req = 0; fast_fill = 1'b1; ovr_en = 1'b0; ovr_val = 2'b00; ready_mode = 0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Only the pong bank full: the controller must keep waiting on ping.
        ovr_en  = 1'b1;
        ovr_val = 2'b10;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("pong_only_rd_en", int'(rd_en), 0);
            check("pong_only_busy", int'(busy), 0);
        end
        ovr_en = 1'b0;

        // Single unstalled row, then ping+pong both full.
        push_rows(1);
        wait_done(200);
        push_rows(2);
        wait_done(200);

        // Three-cycle stall on column 5.
        push_rows(1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(pix_valid && col == 4'd5) && n < 200);
        check("stall_col5_reached", (n < 200) ? 1 : 0, 1);
        ready_mode = 2;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_rd_addr", int'(rd_addr), 6);
            check("stall_col", int'(col), 5);
            check("stall_pix_valid", int'(pix_valid), 1);
            check("stall_rd_en", int'(rd_en), 0);
        end
        ready_mode = 0;
        wait_done(200);

        // Random backpressure and writer pacing across a frame boundary.
        ready_mode = 1;
        fast_fill  = 1'b0;
        push_rows(14);
        wait_done(4000);
        ready_mode = 0;
        fast_fill  = 1'b1;

        // Asynchronous reset in the middle of a row.
        push_rows(1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(rd_en && rd_addr == 4'd7) && n < 200);
        check("mid_row_addr7_reached", (n < 200) ? 1 : 0, 1);
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        pix_q.delete();
        rel_q.delete();
        rows_issued = 0;
        ovr_en  = 1'b1;
        ovr_val = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            check("post_reset_pong_rd_en", int'(rd_en), 0);
            check("post_reset_pong_busy", int'(busy), 0);
        end
        ovr_en = 1'b0;
        push_rows(2);
        wait_done(300);

        repeat (5) @(posedge clk);
        check("pixels_left", pix_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
